// File: rtl/bcd_pkg.sv
// Shared types and helpers for the four-digit BCD counter and display scanner.
package bcd_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef logic [3:0]              bcd_t;
  typedef bcd_t [NUM_DIGITS-1:0]   bcd4_t;

  // Out-of-range nibbles saturate at 9 so the count is always valid BCD.
  function automatic bcd_t bcd_clamp(input bcd_t nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_counter_scan_if.sv
// Control/status bundle between a host and the BCD counter/scanner.
interface bcd_counter_scan_if;

  logic        en;
  logic        inc;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  dig;
  logic [3:0]  an;

  modport master (
    output en, inc, up, clr, load, load_val,
    input  count, wrap, dig, an
  );

  modport slave (
    input  en, inc, up, clr, load, load_val,
    output count, wrap, dig, an
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit register; cells chain units-first through cin/cout.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic up,
  input  logic cin,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t digit,
  output logic cout
);

  bcd_t digit_q;
  bcd_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = bcd_clamp(load_val);
    end else if (step && cin) begin
      if (up) begin
        digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Ripple to the next digit only when this one is rolling over.
  assign cout  = cin & (up ? (digit_q == BCD_MAX) : (digit_q == 4'd0));
  assign digit = digit_q;

endmodule

// File: rtl/bcd_counter_scan.sv
// Four-digit BCD up/down counter with a multiplexed common-anode display scanner.
module bcd_counter_scan
  import bcd_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_counter_scan_if.slave   bus
);

  localparam int              PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic                  step;
  bcd4_t                 digits;
  logic [NUM_DIGITS:0]   carry;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [1:0]            slot_q, slot_d;
  bcd_t                  dig_q, dig_d;
  logic [3:0]            an_q, an_d;
  logic                  wrap_q, wrap_d;
  logic                  sel_blank;

  assign step     = bus.en & bus.inc & ~bus.clr & ~bus.load;
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_cell
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step),
      .up       (bus.up),
      .cin      (carry[g]),
      .clr      (bus.clr),
      .load     (bus.load),
      .load_val (bus.load_val[4*g +: 4]),
      .digit    (digits[g]),
      .cout     (carry[g+1])
    );
  end

  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    slot_d = (pre_q == PRE_LAST) ? slot_q + 2'd1 : slot_q;
    wrap_d = step & carry[NUM_DIGITS];
  end

  // A slot above the units is dark when it and every digit above it are zero.
  always_comb begin
    sel_blank = LZ_BLANK && (slot_q != 2'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(slot_q)) && (digits[i] != 4'd0)) begin
        sel_blank = 1'b0;
      end
    end
  end

  always_comb begin
    dig_d = '0;
    an_d  = 4'b1111;
    if (!sel_blank) begin
      dig_d = digits[slot_q];
      an_d  = ~(4'b0001 << slot_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      slot_q <= 2'd0;
      dig_q  <= '0;
      an_q   <= 4'b1111;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      slot_q <= slot_d;
      dig_q  <= dig_d;
      an_q   <= an_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count = digits;
  assign bus.wrap  = wrap_q;
  assign bus.dig   = dig_q;
  assign bus.an    = an_q;

endmodule
